// File: rtl/dmem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_ctrl_pkg
//   Shared types and constants for the data-memory controller.
//   Contents:
//     dmem_state_e       - two-state access FSM encoding (DMEM_IDLE / DMEM_WAIT)
//     DMEM_DEPTH         - default SRAM depth in 32-bit words
//     ZERO_WORD          - all-zero data word
//     WRITE_ENABLE/..    - SRAM write-enable levels
//     addr_out_of_range  - true when a byte address lies beyond the SRAM.
//                          Only the DMEM_ERR_EN build calls it.
// -----------------------------------------------------------------------------
package dmem_ctrl_pkg;

   localparam int unsigned DMEM_DEPTH    = 4096;
   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
   localparam logic        WRITE_ENABLE  = 1'b1;
   localparam logic        WRITE_DISABLE = 1'b0;

   typedef enum logic {
      DMEM_IDLE = 1'b0,
      DMEM_WAIT = 1'b1
   } dmem_state_e;

   // Any set bit above the word-index field means the access misses the SRAM.
   function automatic logic addr_out_of_range(input logic [31:0] addr,
                                              input int unsigned aw);
      return (addr >> (aw + 2)) != ZERO_WORD;
   endfunction

endpackage : dmem_ctrl_pkg

// File: rtl/dmem_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_ctrl_if
//   EX-stage memory port between the pipeline (master) and dmem_ctrl (slave).
//   Signals:
//     mem_req_i    EX holds a load or store; qualifies every other request field
//     mem_we_i     1 = store, 0 = load
//     mem_raddr_i  byte read address
//     mem_waddr_i  byte write address (equals mem_raddr_i for stores)
//     mem_wdata_i  full merged store word
//     mem_rdata_o  word read from the SRAM
//     hold_req_o   stall request folded into the pipeline hold
//     mem_err_o    out-of-range pulse (DMEM_ERR_EN builds only)
// -----------------------------------------------------------------------------
interface dmem_ctrl_if;

   logic        mem_req_i;
   logic        mem_we_i;
   logic [31:0] mem_raddr_i;
   logic [31:0] mem_waddr_i;
   logic [31:0] mem_wdata_i;
   logic [31:0] mem_rdata_o;
   logic        hold_req_o;
   logic        mem_err_o;

   modport master (
      output mem_req_i, mem_we_i, mem_raddr_i, mem_waddr_i, mem_wdata_i,
      input  mem_rdata_o, hold_req_o, mem_err_o
   );

   modport slave (
      input  mem_req_i, mem_we_i, mem_raddr_i, mem_waddr_i, mem_wdata_i,
      output mem_rdata_o, hold_req_o, mem_err_o
   );

endinterface : dmem_ctrl_if

// File: rtl/dmem_ctrl_sram.sv
// -----------------------------------------------------------------------------
// dmem_sram
//   Single-port synchronous SRAM, one 32-bit word per address.
//   Reads have one cycle of latency and land in an output register. That
//   register changes only when a read is issued (ce=1, we=0) and otherwise
//   holds the last word read.
//   Ports:
//     clk    clock
//     rst    asynchronous active-low reset (clears the read register only)
//     ce     chip enable
//     we     write enable (with ce)
//     addr   word index
//     wdata  write word
//     rdata  registered read word
// -----------------------------------------------------------------------------
module dmem_sram #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // NOTE: the storage array has no reset. Resetting it would turn the RAM into
   // thousands of flops and block RAM inference. Only the output register is
   // reset.
   always_ff @(posedge clk) begin
      if (ce && we) begin
         mem[addr] <= wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments. Every flop then
   // samples its inputs from before the clock edge, whatever order the
   // processes run in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= 32'h0000_0000;
      end else if (ce && !we) begin
         rdata_q <= mem[addr];
      end
   end

   assign rdata = rdata_q;

endmodule : dmem_sram

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//   Data-memory responder for the EX-stage memory port. Every load or store
//   takes two cycles:
//     IDLE - a request issues an SRAM read and raises hold_req_o
//            combinationally, which stalls the pipeline for this cycle.
//     WAIT - the SRAM read word is valid on mem_rdata_o. For a store, EX has
//            merged its bytes into mem_wdata_i, and the word is written on
//            this edge (read-modify-write).
//   Ports:
//     clk   clock
//     rst   asynchronous active-low reset
//     bus   dmem_ctrl_if.slave (request in; rdata / hold / err out)
//   Optional feature DMEM_ERR_EN: addresses above the SRAM are flagged.
//   mem_err_o pulses during WAIT. The read data is forced to zero and the
//   write is dropped. The two-cycle timing does not change. Without the
//   macro, upper address bits alias and mem_err_o is tied low.
// -----------------------------------------------------------------------------
import dmem_ctrl_pkg::*;

module dmem_ctrl #(
   parameter int unsigned DEPTH_WORDS = DMEM_DEPTH,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input logic        clk,
   input logic        rst,
   dmem_ctrl_if.slave bus
);

   dmem_state_e   state_q, state_d;
   logic          err_q, err_d;
   logic          range_err;
   logic          hold_req;
   logic          sram_ce;
   logic          sram_we;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_wdata;
   logic [31:0]   sram_rdata;

   // The access is word-only, so the byte offset is dropped. Upper bits are
   // also dropped unless the range check is built in.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.mem_raddr_i[1:0], bus.mem_waddr_i[1:0],
                               bus.mem_raddr_i[31:AW+2], bus.mem_waddr_i[31:AW+2]};

`ifdef DMEM_ERR_EN
   assign range_err = addr_out_of_range(bus.mem_raddr_i, AW);
`else
   assign range_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= DMEM_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   // NOTE: every output of this block gets a default before the case. No
   // path can leave a signal unassigned, so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      err_d      = 1'b0;
      hold_req   = 1'b0;
      sram_ce    = 1'b0;
      sram_we    = WRITE_DISABLE;
      sram_addr  = bus.mem_raddr_i[AW+1:2];
      sram_wdata = bus.mem_wdata_i;

      unique case (state_q)
         DMEM_IDLE: begin
            if (bus.mem_req_i) begin
               hold_req = 1'b1;
               state_d  = DMEM_WAIT;
               err_d    = range_err;
               // An out-of-range read is not issued. The read register then
               // keeps its last good word, and WAIT forces the output to zero.
               sram_ce  = !range_err;
            end
         end
         DMEM_WAIT: begin
            // The request is frozen in id_ex by the hold, so mem_req_i is not
            // sampled again here.
            state_d = DMEM_IDLE;
            if (bus.mem_we_i && !err_q) begin
               sram_ce   = 1'b1;
               sram_we   = WRITE_ENABLE;
               sram_addr = bus.mem_waddr_i[AW+1:2];
            end
         end
      endcase
   end

   dmem_sram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_sram (
      .clk   (clk),
      .rst   (rst),
      .ce    (sram_ce),
      .we    (sram_we),
      .addr  (sram_addr),
      .wdata (sram_wdata),
      .rdata (sram_rdata)
   );

   // err_q can only be set while in WAIT, so it also acts as the pulse
   // window for the zero-forced data.
   assign bus.hold_req_o  = hold_req;
   assign bus.mem_rdata_o = err_q ? ZERO_WORD : sram_rdata;

`ifdef DMEM_ERR_EN
   assign bus.mem_err_o = err_q;
`else
   assign bus.mem_err_o = 1'b0;
`endif

endmodule : dmem_ctrl
